// File: rtl/video_pkg.sv
// Shared definitions for the video overlay compositor.
// Holds the RGB332 field layout, the OSD foreground colour, the blank glyph
// code, the character RAM word layout and the RGB332 -> RGB888 expansion.
package video_pkg;

  localparam int RGB_R_LSB = 0;
  localparam int RGB_G_LSB = 3;
  localparam int RGB_B_LSB = 6;

  localparam logic [7:0] OSD_FG_RED   = 8'hD5;
  localparam logic [7:0] OSD_FG_GREEN = 8'hC4;
  localparam logic [7:0] OSD_FG_BLUE  = 8'hA1;

  localparam logic [4:0] SPACE_CODE = 5'h1E;

  typedef struct packed {
    logic       blink;
    logic [4:0] code;
  } osd_char_t;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Each field is MSB-aligned in its 8-bit channel, low bits zero.
  function automatic rgb_t expand_rgb332(input logic [7:0] p);
    rgb_t c;
    c.red   = {p[RGB_R_LSB +: 3], 5'b0};
    c.green = {p[RGB_G_LSB +: 3], 5'b0};
    c.blue  = {p[RGB_B_LSB +: 2], 6'b0};
    return c;
  endfunction

endpackage

// File: rtl/font.sv
// Character generator: 8x16 glyphs for 32 codes.
// Ports: code (glyph code), line (0..15), column (0..7) -> pixel (1 = ink).
// Code 5'h1E is the blank glyph.
module font (
  input  logic [4:0] code,
  input  logic [3:0] line,
  input  logic [2:0] column,
  output logic       pixel
);

  assign pixel = (code != 5'h1E) &&
                 (code[line[1:0]] ^ column[0] ^
                  (line[2] & column[1]) ^ (line[3] & column[2]));

endmodule

// File: rtl/osd_char_ram.sv
// OSD character RAM: single write port, registered read port.
// A read of the address being written in the same cycle returns the old word.
// Contents are not initialised or cleared by reset so the array maps onto
// block RAM.
// Ports: clock, we/waddr/wdata (write), raddr -> rdata (one cycle later).
module osd_char_ram #(
  parameter int DEPTH = 768,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [5:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [5:0]    rdata
);

  logic [5:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_overlay_compositor.sv
// Frame-buffer pixel selector with RGB332 expansion and text OSD overlay.
// Three-stage pipeline: S1 counters + frame mux, S2 char RAM read,
// S3 font lookup + mix. Sync and valid travel with the pixel.
// Ports:
//   clock, reset (synchronous, active-high)
//   pixel_valid_in, pixel_x_pos, pixel_y_pos, hsync_in, vsync_in : raster
//   frame_pixels, frame_select : frame-buffer inputs, latched on vsync rise
//   osd_display : OSD enable
//   char_we, char_addr, char_wdata : character RAM write port
//   pixel_red/green/blue, pixel_valid_out, hsync_out, vsync_out : outputs
// Build option: define VIDEO_OSD_BLINK_EN to build the 6-bit vsync counter
// that blanks blink-attributed characters in the upper half of its period.
module video_overlay_compositor
  import video_pkg::*;
#(
  parameter int NUM_FRAMES = 2,
  parameter int OSD_ROWS   = 24,
  parameter int OSD_COLS   = 32,
  parameter int CELL_W     = 10,
  parameter int CELL_H     = 18,
  parameter int OSD_X0     = 160,
  parameter int OSD_Y0     = 24,
  parameter int DIM_SHIFT  = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  pixel_valid_in,
  input  logic [9:0]                            pixel_x_pos,
  input  logic [9:0]                            pixel_y_pos,
  input  logic                                  hsync_in,
  input  logic                                  vsync_in,
  input  logic [8*NUM_FRAMES-1:0]               frame_pixels,
  input  logic [$clog2(NUM_FRAMES)-1:0]         frame_select,
  input  logic                                  osd_display,
  input  logic                                  char_we,
  input  logic [$clog2(OSD_ROWS*OSD_COLS)-1:0]  char_addr,
  input  logic [5:0]                            char_wdata,
  output logic [7:0]                            pixel_red,
  output logic [7:0]                            pixel_green,
  output logic [7:0]                            pixel_blue,
  output logic                                  pixel_valid_out,
  output logic                                  hsync_out,
  output logic                                  vsync_out
);

  localparam int FW    = $clog2(NUM_FRAMES);
  localparam int CHARS = OSD_ROWS * OSD_COLS;
  localparam int AW    = $clog2(CHARS);
  localparam int CCW   = $clog2(CELL_W);
  localparam int CLW   = $clog2(CELL_H);
  localparam int COLW  = $clog2(OSD_COLS);
  localparam int ROWW  = $clog2(OSD_ROWS);
  localparam int X_END = OSD_X0 + OSD_COLS * CELL_W - 1;
  localparam int Y_END = OSD_Y0 + OSD_ROWS * CELL_H - 1;
  localparam logic [FW:0] FRAME_LIMIT = NUM_FRAMES[FW:0];

  // ---------------- S1: counters and frame mux ----------------
  logic            vs_prev;
  logic            vs_rise;
  logic            frame_ok;
  logic [FW-1:0]   active_frame;
  logic [7:0]      frames [NUM_FRAMES];

  logic [CCW-1:0]  cell_col, cell_col_n;
  logic [COLW-1:0] col, col_n;
  logic [CLW-1:0]  cell_line, cell_line_n;
  logic [ROWW-1:0] row, row_n;
  logic            at_x0, in_x, in_y;
  logic            blink_phase;

  logic            s1_valid, s1_hsync, s1_vsync, s1_osd, s1_blink_phase;
  rgb_t            s1_rgb;

  assign vs_rise  = vsync_in & ~vs_prev;
  assign frame_ok = {1'b0, frame_select} < FRAME_LIMIT;
  assign at_x0    = pixel_x_pos == 10'(OSD_X0);
  assign in_x     = (pixel_x_pos >= 10'(OSD_X0)) && (pixel_x_pos <= 10'(X_END));
  assign in_y     = (pixel_y_pos >= 10'(OSD_Y0)) && (pixel_y_pos <= 10'(Y_END));

  always_comb begin
    for (int f = 0; f < NUM_FRAMES; f++) frames[f] = frame_pixels[8*f +: 8];
  end

  // Incremental cell tracking: the x counters restart at the OSD left edge,
  // the y counters step once per line on that same pixel.
  always_comb begin
    cell_col_n  = cell_col;
    col_n       = col;
    cell_line_n = cell_line;
    row_n       = row;
    if (pixel_valid_in && at_x0) begin
      cell_col_n = '0;
      col_n      = '0;
      if (pixel_y_pos == 10'(OSD_Y0)) begin
        cell_line_n = '0;
        row_n       = '0;
      end else if (cell_line == CLW'(CELL_H - 1)) begin
        cell_line_n = '0;
        row_n       = row + 1'b1;
      end else begin
        cell_line_n = cell_line + 1'b1;
      end
    end else if (pixel_valid_in && in_x) begin
      if (cell_col == CCW'(CELL_W - 1)) begin
        cell_col_n = '0;
        col_n      = col + 1'b1;
      end else begin
        cell_col_n = cell_col + 1'b1;
      end
    end
  end

`ifdef VIDEO_OSD_BLINK_EN
  logic [5:0] blink_cnt;

  always_ff @(posedge clock) begin
    if (reset) blink_cnt <= '0;
    else if (vs_rise) blink_cnt <= blink_cnt + 1'b1;
  end

  assign blink_phase = blink_cnt[5];
`else
  assign blink_phase = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      vs_prev        <= 1'b0;
      active_frame   <= '0;
      cell_col       <= '0;
      col            <= '0;
      cell_line      <= '0;
      row            <= '0;
      s1_valid       <= 1'b0;
      s1_hsync       <= 1'b0;
      s1_vsync       <= 1'b0;
      s1_osd         <= 1'b0;
      s1_blink_phase <= 1'b0;
      s1_rgb         <= '0;
    end else begin
      vs_prev        <= vsync_in;
      if (vs_rise && frame_ok) active_frame <= frame_select;
      cell_col       <= cell_col_n;
      col            <= col_n;
      cell_line      <= cell_line_n;
      row            <= row_n;
      s1_valid       <= pixel_valid_in;
      s1_hsync       <= hsync_in;
      s1_vsync       <= vsync_in;
      s1_osd         <= pixel_valid_in && osd_display && in_x && in_y;
      // Blink phase is captured with the pixel so a vsync edge cannot split it.
      s1_blink_phase <= blink_phase;
      s1_rgb         <= expand_rgb332(frames[active_frame]);
    end
  end

  // ---------------- S2: character RAM read ----------------
  logic [AW-1:0] ram_raddr;
  logic [5:0]    ram_rdata;
  logic          s2_valid, s2_hsync, s2_vsync, s2_osd, s2_border, s2_blink_phase;
  logic [3:0]    s2_glyph_line;
  logic [2:0]    s2_glyph_col;
  rgb_t          s2_rgb;

  assign ram_raddr = AW'(row) * AW'(OSD_COLS) + AW'(col);

  osd_char_ram #(
    .DEPTH (CHARS),
    .AW    (AW)
  ) u_char_ram (
    .clock (clock),
    .we    (char_we),
    .waddr (char_addr),
    .wdata (char_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid       <= 1'b0;
      s2_hsync       <= 1'b0;
      s2_vsync       <= 1'b0;
      s2_osd         <= 1'b0;
      s2_border      <= 1'b0;
      s2_blink_phase <= 1'b0;
      s2_glyph_line  <= '0;
      s2_glyph_col   <= '0;
      s2_rgb         <= '0;
    end else begin
      s2_valid       <= s1_valid;
      s2_hsync       <= s1_hsync;
      s2_vsync       <= s1_vsync;
      s2_osd         <= s1_osd;
      s2_border      <= (cell_line == '0) || (cell_line == CLW'(CELL_H - 1)) ||
                        (cell_col == '0)  || (cell_col == CCW'(CELL_W - 1));
      s2_blink_phase <= s1_blink_phase;
      s2_glyph_line  <= 4'(cell_line - 1'b1);
      s2_glyph_col   <= 3'(cell_col - 1'b1);
      s2_rgb         <= s1_rgb;
    end
  end

  // ---------------- S3: font lookup and mix ----------------
  osd_char_t s2_char;
  logic      font_pixel;
  logic      glyph_on;

  assign s2_char = osd_char_t'(ram_rdata);

  font u_font (
    .code   (s2_char.code),
    .line   (s2_glyph_line),
    .column (s2_glyph_col),
    .pixel  (font_pixel)
  );

  assign glyph_on = s2_osd && !s2_border && font_pixel &&
                    !(s2_char.blink && s2_blink_phase);

  always_ff @(posedge clock) begin
    if (reset) begin
      pixel_red       <= '0;
      pixel_green     <= '0;
      pixel_blue      <= '0;
      pixel_valid_out <= 1'b0;
      hsync_out       <= 1'b0;
      vsync_out       <= 1'b0;
    end else begin
      pixel_valid_out <= s2_valid;
      hsync_out       <= s2_hsync;
      vsync_out       <= s2_vsync;
      if (!s2_valid) begin
        pixel_red   <= '0;
        pixel_green <= '0;
        pixel_blue  <= '0;
      end else if (glyph_on) begin
        pixel_red   <= OSD_FG_RED;
        pixel_green <= OSD_FG_GREEN;
        pixel_blue  <= OSD_FG_BLUE;
      end else if (s2_osd) begin
        pixel_red   <= s2_rgb.red   >> DIM_SHIFT;
        pixel_green <= s2_rgb.green >> DIM_SHIFT;
        pixel_blue  <= s2_rgb.blue  >> DIM_SHIFT;
      end else begin
        pixel_red   <= s2_rgb.red;
        pixel_green <= s2_rgb.green;
        pixel_blue  <= s2_rgb.blue;
      end
    end
  end

endmodule

// File: tb/tb_video_overlay_compositor.sv
module tb_video_overlay_compositor;

  localparam int NF = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        pixel_valid_in;
  logic [9:0]  pixel_x_pos, pixel_y_pos;
  logic        hsync_in, vsync_in;
  logic [23:0] frame_pixels;
  logic [1:0]  frame_select;
  logic        osd_display, char_we;
  logic [9:0]  char_addr;
  logic [5:0]  char_wdata;
  logic [7:0]  pixel_red, pixel_green, pixel_blue;
  logic        pixel_valid_out, hsync_out, vsync_out;

  video_overlay_compositor #(.NUM_FRAMES(NF)) dut (
    .clock(clock), .reset(reset),
    .pixel_valid_in(pixel_valid_in), .pixel_x_pos(pixel_x_pos), .pixel_y_pos(pixel_y_pos),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_pixels(frame_pixels), .frame_select(frame_select), .osd_display(osd_display),
    .char_we(char_we), .char_addr(char_addr), .char_wdata(char_wdata),
    .pixel_red(pixel_red), .pixel_green(pixel_green), .pixel_blue(pixel_blue),
    .pixel_valid_out(pixel_valid_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [9:0]  x, y;
    logic        hs, vs;
    logic [23:0] fp;
    logic [1:0]  sel;
    logic        osd;
    logic        we;
    logic [9:0]  addr;
    logic [5:0]  wd;
  } stim_t;

  stim_t       sq[$];
  logic [26:0] exp_q[$];
  logic [26:0] due;
  bit          have_due;
  int          total = 0;
  int          bad = 0;

  // Reference model state
  logic [5:0] shadow [768];
  int         act = 0;
  bit         vs_prev_m = 0;
  int         blink_m = 0;
  logic [1:0] cur_sel = 0;

  function automatic bit fnt(input int code, input int line, input int col);
    if (code == 30) return 0;
    return (((code >> (line % 4)) & 1) ^ (col % 2) ^
            (((line / 4) % 2) & ((col / 2) % 2)) ^
            (((line / 8) % 2) & ((col / 4) % 2))) != 0;
  endfunction

  // Whole-pixel reference: decides the pixel from raster position with
  // division, a shadow copy of the RAM and vsync-edge bookkeeping.
  function automatic logic [26:0] model(input stim_t s);
    logic [7:0] p, r, g, b;
    int dx, dy, cc, cl, c, rw;
    logic [5:0] ch;
    bit glyph;
    if (s.rst) begin
      act = 0; vs_prev_m = 0; blink_m = 0;
      return '0;
    end
    if (s.we) shadow[s.addr] = s.wd;
    r = 0; g = 0; b = 0;
    if (s.v) begin
      p = 8'((s.fp >> (8 * act)) & 24'hFF);
      r = 8'((p % 8) * 32);
      g = 8'(((p / 8) % 8) * 32);
      b = 8'((p / 64) * 64);
      if (s.osd && s.x >= 160 && s.x <= 479 && s.y >= 24 && s.y <= 455) begin
        dx = int'(s.x) - 160; dy = int'(s.y) - 24;
        cc = dx % 10; c = dx / 10; cl = dy % 18; rw = dy / 18;
        glyph = 0;
        if (cc >= 1 && cc <= 8 && cl >= 1 && cl <= 16) begin
          ch = shadow[rw * 32 + c];
          glyph = fnt(int'(ch[4:0]), cl - 1, cc - 1);
`ifdef VIDEO_OSD_BLINK_EN
          if (ch[5] && blink_m >= 32) glyph = 0;
`endif
        end
        if (glyph) begin
          r = 8'hD5; g = 8'hC4; b = 8'hA1;
        end else begin
          r = r >> 3; g = g >> 3; b = b >> 3;
        end
      end
    end
    if (s.vs && !vs_prev_m) begin
      if (int'(s.sel) < NF) act = int'(s.sel);
      blink_m = (blink_m + 1) % 64;
    end
    vs_prev_m = s.vs;
    return {r, g, b, s.v, s.hs, s.vs};
  endfunction

  task automatic step(input stim_t s);
    logic [26:0] e;
    reset = s.rst; pixel_valid_in = s.v; pixel_x_pos = s.x; pixel_y_pos = s.y;
    hsync_in = s.hs; vsync_in = s.vs; frame_pixels = s.fp; frame_select = s.sel;
    osd_display = s.osd; char_we = s.we; char_addr = s.addr; char_wdata = s.wd;
    e = model(s);
    if (s.rst) foreach (exp_q[i]) exp_q[i] = '0;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    have_due = 0;
    if (exp_q.size() == 3) begin
      due = exp_q.pop_front();
      have_due = 1;
    end
  endtask

  function automatic stim_t mk(input logic v, input int x, input int y,
                               input logic [23:0] fp, input logic osd);
    stim_t s;
    s.rst = 0; s.v = v; s.x = 10'(x); s.y = 10'(y);
    s.hs = 1'($urandom % 2); s.vs = 0; s.fp = fp; s.sel = cur_sel;
    s.osd = osd; s.we = 0; s.addr = '0; s.wd = '0;
    return s;
  endfunction

  function automatic stim_t idle();
    return mk(1'b0, 0, 0, 24'($urandom), 1'b0);
  endfunction

  task automatic push_vsync();
    stim_t s;
    for (int i = 0; i < 4; i++) begin
      s = idle();
      s.vs = (i < 2);
      sq.push_back(s);
    end
  endtask

  task automatic test_reset();
    stim_t s;
    for (int i = 0; i < 6; i++) begin s = idle(); s.rst = 1; sq.push_back(s); end
    for (int i = 0; i < 10; i++) sq.push_back(mk(1'b1, i, 2, 24'($urandom), 1'b0));
    for (int i = 0; i < 5; i++) begin
      s = mk(1'b1, 20 + i, 2, 24'($urandom), 1'b0);
      s.rst = 1;
      sq.push_back(s);
    end
    for (int i = 0; i < 10; i++) sq.push_back(mk(1'b1, 30 + i, 2, 24'($urandom), 1'b0));
    foreach (sq[i]) begin
      step(sq[i]);
      if (have_due) begin
        total++;
        if ({pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out} !== due) begin
          bad++;
          $display("FAIL reset step %0d: got %h required %h", i,
                   {pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out}, due);
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_char_ram();
    stim_t s;
    for (int a = 0; a < 768; a++) begin
      s = idle(); s.we = 1; s.addr = 10'(a); s.wd = 6'($urandom);
      sq.push_back(s);
    end
    s = idle(); s.we = 1; s.addr = 10'd0; s.wd = 6'h0A;
    sq.push_back(s);
    for (int y = 24; y <= 26; y++)
      for (int x = 159; x <= 166; x++) sq.push_back(mk(1'b1, x, y, 24'hFFFFFF, 1'b1));
    foreach (sq[i]) begin
      step(sq[i]);
      if (have_due) begin
        total++;
        if ({pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out} !== due) begin
          bad++;
          $display("FAIL char_ram step %0d: got %h required %h", i,
                   {pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out}, due);
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_frame_select();
    logic [1:0] seq [5];
    seq[0] = 2'd3; seq[1] = 2'd2; seq[2] = 2'd1; seq[3] = 2'd3; seq[4] = 2'd0;
    cur_sel = 0;
    for (int x = 0; x < 20; x++) begin
      if (x == 10) cur_sel = 2;
      sq.push_back(mk(1'b1, x, 5, {8'hFF, 16'($urandom)}, 1'($urandom % 2)));
    end
    for (int k = 0; k < 5; k++) begin
      cur_sel = seq[k];
      push_vsync();
      for (int x = 0; x < 12; x++)
        sq.push_back(mk(1'b1, x, 6 + k, {8'hFF, 16'($urandom)}, 1'($urandom % 2)));
    end
    foreach (sq[i]) begin
      step(sq[i]);
      if (have_due) begin
        total++;
        if ({pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out} !== due) begin
          bad++;
          $display("FAIL frame_select step %0d: got %h required %h", i,
                   {pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out}, due);
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_counter_wrap();
    bit full;
    for (int y = 22; y <= 458; y++) begin
      full = (y >= 24 && y <= 41) || (y >= 438 && y <= 455);
      if (full) begin
        for (int x = 158; x <= 481; x++)
          sq.push_back(mk(1'b1, x, y, 24'($urandom), 1'($urandom % 8 != 0)));
      end else begin
        sq.push_back(mk(1'b1, 160, y, 24'($urandom), 1'b1));
      end
    end
    foreach (sq[i]) begin
      step(sq[i]);
      if (have_due) begin
        total++;
        if ({pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out} !== due) begin
          bad++;
          $display("FAIL counter_wrap step %0d: got %h required %h", i,
                   {pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out}, due);
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_collision();
    stim_t s;
    s = idle(); s.we = 1; s.addr = 10'd3; s.wd = 6'h0A;
    sq.push_back(s);
    for (int y = 24; y <= 28; y++) sq.push_back(mk(1'b1, 160, y, 24'($urandom), 1'b1));
    for (int y = 29; y <= 30; y++)
      for (int x = 160; x <= 199; x++) begin
        s = mk(1'b1, x, y, 24'($urandom), 1'b1);
        if (y == 29 && x == 195) begin s.we = 1; s.addr = 10'd3; s.wd = 6'h0B; end
        sq.push_back(s);
      end
    foreach (sq[i]) begin
      step(sq[i]);
      if (have_due) begin
        total++;
        if ({pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out} !== due) begin
          bad++;
          $display("FAIL collision step %0d: got %h required %h", i,
                   {pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out}, due);
        end
      end
    end
    sq.delete();
  endtask

  task automatic test_blink();
    stim_t s;
    s = idle(); s.we = 1; s.addr = 10'd5; s.wd = 6'h2A;
    sq.push_back(s);
    for (int f = 0; f < 64; f++) begin
      push_vsync();
      for (int y = 24; y <= 26; y++)
        for (int x = 160; x <= 219; x++)
          sq.push_back(mk(1'b1, x, y, 24'($urandom), 1'b1));
    end
    for (int i = 0; i < 4; i++) sq.push_back(idle());
    foreach (sq[i]) begin
      step(sq[i]);
      if (have_due) begin
        total++;
        if ({pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out} !== due) begin
          bad++;
          $display("FAIL blink step %0d: got %h required %h", i,
                   {pixel_red, pixel_green, pixel_blue, pixel_valid_out, hsync_out, vsync_out}, due);
        end
      end
    end
    sq.delete();
  endtask

  initial begin
    reset = 1; pixel_valid_in = 0; pixel_x_pos = 0; pixel_y_pos = 0;
    hsync_in = 0; vsync_in = 0; frame_pixels = 0; frame_select = 0;
    osd_display = 0; char_we = 0; char_addr = 0; char_wdata = 0;
    test_reset();
    test_char_ram();
    test_frame_select();
    test_counter_wrap();
    test_collision();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
